// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states, instruction fields and control table for cpu_sequencer
package cpu_pkg;

  localparam logic [3:0] OP_SET    = 4'd0;
  localparam logic [3:0] OP_COPY   = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_INC    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_DEC    = 4'd5;
  localparam logic [3:0] OP_AND    = 4'd6;
  localparam logic [3:0] OP_OR     = 4'd7;
  localparam logic [3:0] OP_XOR    = 4'd8;
  localparam logic [3:0] OP_SKIPIF = 4'd9;
  localparam logic [3:0] OP_HALT   = 4'd10;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic [2:0] s;
    logic       c;
    logic       b;
    logic       writes;
  } op_ctrl_t;

  // Non-writing opcodes (skipif, halt, illegal) map to all-zero, i.e. writes=0.
  function automatic op_ctrl_t op_ctrl(input logic [3:0] op);
    op_ctrl_t r;
    r = '0;
    case (op)
      OP_SET:  r = '{s: 3'b111, c: 1'b0, b: 1'b0, writes: 1'b1};
      OP_COPY: r = '{s: 3'b000, c: 1'b0, b: 1'b0, writes: 1'b1};
      OP_ADD:  r = '{s: 3'b001, c: 1'b0, b: 1'b1, writes: 1'b1};
      OP_INC:  r = '{s: 3'b000, c: 1'b1, b: 1'b0, writes: 1'b1};
      OP_SUB:  r = '{s: 3'b010, c: 1'b1, b: 1'b1, writes: 1'b1};
      OP_DEC:  r = '{s: 3'b011, c: 1'b0, b: 1'b0, writes: 1'b1};
      OP_AND:  r = '{s: 3'b100, c: 1'b0, b: 1'b1, writes: 1'b1};
      OP_OR:   r = '{s: 3'b100, c: 1'b1, b: 1'b1, writes: 1'b1};
      OP_XOR:  r = '{s: 3'b101, c: 1'b0, b: 1'b1, writes: 1'b1};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction memory req/valid fetch bus
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            valid;
  logic [15:0]     data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/cpu_sequencer_op_ctrl_lut.sv
// rtl/cpu_sequencer_op_ctrl_lut.sv - combinational opcode to ALU control decode
module op_ctrl_lut
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_s,
  output logic       alu_c,
  output logic       alu_b,
  output logic       writes,
  output logic       legal
);
  op_ctrl_t ctrl;

  assign ctrl   = op_ctrl(opcode);
  assign alu_s  = ctrl.s;
  assign alu_c  = ctrl.c;
  assign alu_b  = ctrl.b;
  assign writes = ctrl.writes;
  assign legal  = (opcode <= OP_HALT);
endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute sequencer owning PC, IR and the zero flag
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  cpu_sequencer_if.master        imem,
  input  logic                   zero_flag,
  output logic [2:0]             alu_s,
  output logic                   alu_c,
  output logic                   alu_b,
  output logic [1:0]             rd_addr,
  output logic [1:0]             rs_addr,
  output logic [7:0]             imm,
  output logic                   rf_we,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal
);
  state_t          state, state_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic [15:0]     ir;
  logic            z;
  logic            ir_load, ctrl_load, z_load;

  logic [3:0] opcode;
  logic [2:0] lut_s;
  logic       lut_c, lut_b, lut_writes, lut_legal;

  assign opcode = ir[OPC_HI:OPC_LO];

  op_ctrl_lut u_lut (
    .opcode (opcode),
    .alu_s  (lut_s),
    .alu_c  (lut_c),
    .alu_b  (lut_b),
    .writes (lut_writes),
    .legal  (lut_legal)
  );

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_load   = 1'b0;
    ctrl_load = 1'b0;
    z_load    = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_nx    = '0;
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem.valid) begin
          ir_load  = 1'b1;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Only write ops touch the control registers; the rest leave them as they were.
        ctrl_load = lut_writes;
        state_nx  = ST_EXEC;
      end
      ST_EXEC: begin
        state_nx = ST_FETCH;
        if (lut_writes) begin
          z_load = 1'b1;
          pc_nx  = pc + PC_W'(1);
        end else if (opcode == OP_SKIPIF) begin
          pc_nx = pc + (z ? PC_W'(2) : PC_W'(1));
        end else if (opcode == OP_HALT) begin
          state_nx = ST_HALTED;
        end else begin
          pc_nx = pc + PC_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      ir      <= '0;
      z       <= 1'b0;
      alu_s   <= '0;
      alu_c   <= 1'b0;
      alu_b   <= 1'b0;
      rd_addr <= '0;
      rs_addr <= '0;
      imm     <= '0;
    end else begin
      pc <= pc_nx;
      if (ir_load) ir <= imem.data;
      if (z_load)  z  <= zero_flag;
      if (ctrl_load) begin
        alu_s   <= lut_s;
        alu_c   <= lut_c;
        alu_b   <= lut_b;
        rd_addr <= ir[RD_HI:RD_LO];
        rs_addr <= ir[RS_HI:RS_LO];
        imm     <= ir[IMM_HI:IMM_LO];
      end
    end
  end

  // Strobes decode straight from registered state so a reset kills them immediately.
  assign imem.req  = (state == ST_FETCH);
  assign imem.addr = pc;
  assign rf_we     = (state == ST_EXEC) && lut_writes;
  assign busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  assign halted    = (state == ST_HALTED);
  assign illegal   = (state == ST_DECODE) && !lut_legal;
endmodule
